// File: rtl/fuse_pkg.sv
// Shared constants for the fuse shadow loader: word map offsets and FSM states.
package fuse_pkg;

  localparam int NUM_FUSE_WORDS = 33;
  localparam int KEY_WORDS      = 6;
  localparam int ACCT_WORDS     = 3;

  localparam int AES0_BASE    = 0;
  localparam int AES1_BASE    = 6;
  localparam int AES2_BASE    = 12;
  localparam int SHA_BASE     = 18;
  localparam int ACCT_M0_BASE = 24;
  localparam int ACCT_M1_BASE = 27;
  localparam int ACCT_M2_BASE = 30;

  typedef enum logic [1:0] {
    FUSE_IDLE  = 2'd0,
    FUSE_LOAD  = 2'd1,
    FUSE_DRAIN = 2'd2,
    FUSE_DONE  = 2'd3
  } fuse_rd_state_e;

endpackage

// File: rtl/fuse_reader.sv
// Boot-time fuse loader: streams words 0..NUM_WORDS-1 into a shadow array and
// exposes key / access-control fields only once a full load has completed.
module fuse_reader
  import fuse_pkg::*;
#(
  parameter int NUM_WORDS = 33,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              fuse_req_o,
  output logic [ADDR_W-1:0] fuse_addr_o,
  input  logic [31:0]       fuse_rdata_i,
  output logic [191:0]      aes_key0_o,
  output logic [191:0]      aes_key1_o,
  output logic [191:0]      aes_key2_o,
  output logic [191:0]      sha_key_o,
  output logic [95:0]       acct_m0_o,
  output logic [95:0]       acct_m1_o,
  output logic [95:0]       acct_m2_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int ARR_W = (NUM_WORDS > 0) ? NUM_WORDS : 1;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((NUM_WORDS > 0) ? NUM_WORDS - 1 : 0);
  localparam fuse_rd_state_e RST_STATE = (NUM_WORDS > 0) ? FUSE_LOAD : FUSE_IDLE;

  fuse_rd_state_e           state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ARR_W-1:0][31:0]   shadow_q, shadow_d;
  logic                     cap_en;
  logic [IDX_W-1:0]         cap_idx;

  // Read data lags the request by one cycle, so LOAD captures the word
  // requested in the previous cycle and DRAIN picks up the final one.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    cap_en   = 1'b0;
    cap_idx  = '0;
    case (state_q)
      FUSE_LOAD: begin
        if (idx_q != '0) begin
          cap_en  = 1'b1;
          cap_idx = idx_q - 1'b1;
        end
        if (idx_q == LAST_IDX) state_d = FUSE_DRAIN;
        else                   idx_d   = idx_q + 1'b1;
      end
      FUSE_DRAIN: begin
        cap_en  = 1'b1;
        cap_idx = idx_q;
        state_d = FUSE_DONE;
      end
      FUSE_DONE: begin
        if (start_i) begin
          shadow_d = '0;
          idx_d    = '0;
          state_d  = FUSE_LOAD;
        end
      end
      default: ;
    endcase
    for (int i = 0; i < ARR_W; i++) begin
      if (cap_en && cap_idx == IDX_W'(i)) shadow_d[i] = fuse_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RST_STATE;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  assign fuse_req_o  = (state_q == FUSE_LOAD);
  assign fuse_addr_o = fuse_req_o ? ADDR_W'(idx_q) : '0;
  assign busy_o      = (state_q == FUSE_LOAD) || (state_q == FUSE_DRAIN);
  assign done_o      = (state_q == FUSE_DONE) || (state_q == FUSE_IDLE);

  // Pad the shadow view to the full word map so short arrays read as zero.
  logic [NUM_FUSE_WORDS-1:0][31:0] word_w;
  for (genvar g = 0; g < NUM_FUSE_WORDS; g++) begin : g_word
    if (g < NUM_WORDS) begin : g_hit
      assign word_w[g] = shadow_q[g];
    end else begin : g_pad
      assign word_w[g] = '0;
    end
  end

  logic [191:0] key_mask;
  logic [95:0]  acct_mask;
  assign key_mask  = {192{done_o}};
  assign acct_mask = {96{done_o}};

  assign aes_key0_o = word_w[AES0_BASE    +: KEY_WORDS]  & key_mask;
  assign aes_key1_o = word_w[AES1_BASE    +: KEY_WORDS]  & key_mask;
  assign aes_key2_o = word_w[AES2_BASE    +: KEY_WORDS]  & key_mask;
  assign sha_key_o  = word_w[SHA_BASE     +: KEY_WORDS]  & key_mask;
  assign acct_m0_o  = word_w[ACCT_M0_BASE +: ACCT_WORDS] & acct_mask;
  assign acct_m1_o  = word_w[ACCT_M1_BASE +: ACCT_WORDS] & acct_mask;
  assign acct_m2_o  = word_w[ACCT_M2_BASE +: ACCT_WORDS] & acct_mask;

endmodule

// File: tb/tb_fuse_reader.sv
// Randomized bench for fuse_reader: fuse memory model plus word-map reference.
module tb_fuse_reader;

  localparam int NW = 33;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          fuse_req_o;
  logic [31:0]   fuse_addr_o;
  logic [31:0]   fuse_rdata_i = '0;
  logic [191:0]  aes_key0_o, aes_key1_o, aes_key2_o, sha_key_o;
  logic [95:0]   acct_m0_o, acct_m1_o, acct_m2_o;
  logic          busy_o, done_o;

  logic [31:0]   mem [NW];
  int            n_chk = 0;
  int            n_pass = 0;
  bit            aborted;

  fuse_reader #(.NUM_WORDS(NW), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .fuse_req_o(fuse_req_o), .fuse_addr_o(fuse_addr_o), .fuse_rdata_i(fuse_rdata_i),
    .aes_key0_o(aes_key0_o), .aes_key1_o(aes_key1_o), .aes_key2_o(aes_key2_o),
    .sha_key_o(sha_key_o), .acct_m0_o(acct_m0_o), .acct_m1_o(acct_m1_o),
    .acct_m2_o(acct_m2_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Fuse memory: one-cycle read latency, junk on the bus when not requested.
  always @(posedge clk_i) begin
    if (fuse_req_o)
      fuse_rdata_i <= (fuse_addr_o < NW) ? mem[fuse_addr_o[5:0]] : 32'hDEAD_BEEF;
    else
      fuse_rdata_i <= $urandom;
  end

  task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h want %h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic [191:0] fld(input int base, input int n);
    logic [191:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[32*j +: 32] = mem[base + j];
    return r;
  endfunction

  task automatic chk_fields(input string tag);
    chk({tag, " aes0"}, aes_key0_o, fld(0, 6));
    chk({tag, " aes1"}, aes_key1_o, fld(6, 6));
    chk({tag, " aes2"}, aes_key2_o, fld(12, 6));
    chk({tag, " sha"},  sha_key_o,  fld(18, 6));
    chk({tag, " m0"},   {96'd0, acct_m0_o}, fld(24, 3));
    chk({tag, " m1"},   {96'd0, acct_m1_o}, fld(27, 3));
    chk({tag, " m2"},   {96'd0, acct_m2_o}, fld(30, 3));
  endtask

  function automatic logic any_out();
    return |{aes_key0_o, aes_key1_o, aes_key2_o, sha_key_o, acct_m0_o, acct_m1_o, acct_m2_o};
  endfunction

  // Entered at the negedge of load cycle 0; leaves at the negedge of cycle 34.
  task automatic run_load(input int start_at, input int rst_at, output bit ab);
    ab = 1'b0;
    for (int c = 0; c <= NW + 1; c++) begin
      if (c <= NW - 1) begin
        chk($sformatf("c%0d req", c),  192'(fuse_req_o), 192'd1);
        chk($sformatf("c%0d addr", c), 192'(fuse_addr_o), 192'(c));
      end else begin
        chk($sformatf("c%0d req", c),  192'(fuse_req_o), 192'd0);
      end
      if (c <= NW) begin
        chk($sformatf("c%0d busy/done", c), 192'({busy_o, done_o}), 192'b10);
        chk($sformatf("c%0d gated", c), 192'(any_out()), 192'd0);
      end else begin
        chk($sformatf("c%0d busy/done", c), 192'({busy_o, done_o}), 192'b01);
        chk_fields("load");
      end
      if (c == rst_at) begin
        start_i = 1'b0;
        rst_i   = 1'b1;
        @(negedge clk_i);
        rst_i   = 1'b0;
        ab      = 1'b1;
        return;
      end
      start_i = (c == start_at);
      if (c <= NW) @(negedge clk_i);
    end
    start_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle req", 192'(fuse_req_o), 192'd0);
      chk("idle addr bound", 192'(fuse_addr_o < NW), 192'd1);
      chk("idle busy/done", 192'({busy_o, done_o}), 192'b01);
      chk("idle aes0", aes_key0_o, fld(0, 6));
      @(negedge clk_i);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = 32'hA5A5_0000 + i;
    repeat (3) @(negedge clk_i);
    chk("rst req",  192'(fuse_req_o), 192'd1);
    chk("rst addr", 192'(fuse_addr_o), 192'd0);
    chk("rst busy/done", 192'({busy_o, done_o}), 192'b10);
    chk("rst gated", 192'(any_out()), 192'd0);
    rst_i = 1'b0;

    // Boot load without start_i
    run_load(-1, -1, aborted);
    chk("boot aes0 w0", 192'(aes_key0_o[31:0]), 192'(32'hA5A5_0000));
    chk("boot m2 w2",   192'(acct_m2_o[95:64]), 192'(32'hA5A5_0020));
    idle_cycles(20);

    // Reload with a new fuse image
    for (int i = 0; i < NW; i++) mem[i] = 32'h5A5A_0000 + i;
    pulse_start();
    run_load(-1, -1, aborted);
    chk("reload sha w0", 192'(sha_key_o[31:0]), 192'(32'h5A5A_0012));
    idle_cycles(3);

    // start_i mid-load is dropped; no second load afterwards
    fill_rand();
    pulse_start();
    run_load(10, -1, aborted);
    idle_cycles(5);
    for (int k = 0; k < 4; k++) begin
      fill_rand();
      pulse_start();
      run_load($urandom_range(0, NW), -1, aborted);
      idle_cycles(5);
    end

    // Reset mid-load restarts from word 0
    fill_rand();
    pulse_start();
    run_load(-1, 15, aborted);
    chk("rst15 taken", 192'(aborted), 192'd1);
    run_load(-1, -1, aborted);
    idle_cycles(3);
    for (int k = 0; k < 3; k++) begin
      fill_rand();
      pulse_start();
      run_load(-1, $urandom_range(0, NW + 1), aborted);
      fill_rand();
      run_load(-1, -1, aborted);
      idle_cycles(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
